// File: rtl/signed_divmod_recon.sv
// Signed dividend reconstruction: sa = q*b + r via a shift-add multiplier,
// with overflow, remainder-consistency and divide-by-zero flags.
module signed_divmod_recon #(
    parameter int W = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic signed [W-1:0] in_q,
    input  logic signed [W-1:0] in_r,
    input  logic signed [W-1:0] in_b,
    output logic                out_valid,
    input  logic                out_ready,
    output logic signed [W-1:0] out_sa,
    output logic                out_ovf,
    output logic                out_rem_bad,
    output logic                out_div0
);

    localparam int CW = (W > 1) ? $clog2(W) : 1;

    typedef enum logic [1:0] {IDLE, MUL, ADD, DONE} state_t;

    state_t               state;
    state_t               state_nx;
    logic [W-1:0]         q_mag;
    logic [W-1:0]         b_mag;
    logic                 neg;
    logic signed [W-1:0]  r_reg;
    logic [CW-1:0]        cnt;
    logic [2*W-1:0]       acc;
    logic [2*W:0]         prod;
    logic [2*W:0]         sum;
    logic [W:0]           r_abs;
    logic [W-1:0]         q_abs_in;
    logic [W-1:0]         b_abs_in;
    logic                 ovf_nx;
    logic                 bad_nx;

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);

    // |-2^(W-1)| is representable as an unsigned W-bit magnitude
    assign q_abs_in = in_q[W-1] ? (~in_q + W'(1)) : in_q;
    assign b_abs_in = in_b[W-1] ? (~in_b + W'(1)) : in_b;

    always_comb begin
        prod   = neg ? (~{1'b0, acc} + (2*W+1)'(1)) : {1'b0, acc};
        sum    = prod + {{(W+1){r_reg[W-1]}}, r_reg};
        r_abs  = r_reg[W-1] ? (~{1'b1, r_reg} + (W+1)'(1)) : {1'b0, r_reg};
        // in range iff the top W+2 bits are a pure sign extension
        ovf_nx = !((&sum[2*W:W-1]) || !(|sum[2*W:W-1]));
        bad_nx = (r_reg != '0) &&
                 ((r_abs >= {1'b0, b_mag}) || (r_reg[W-1] != sum[2*W]));
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE: if (in_valid) state_nx = (in_b == '0) ? DONE : MUL;
            MUL:  if (cnt == CW'(W-1)) state_nx = ADD;
            ADD:  state_nx = DONE;
            DONE: if (out_ready) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            q_mag       <= '0;
            b_mag       <= '0;
            neg         <= 1'b0;
            r_reg       <= '0;
            cnt         <= '0;
            acc         <= '0;
            out_sa      <= '0;
            out_ovf     <= 1'b0;
            out_rem_bad <= 1'b0;
            out_div0    <= 1'b0;
        end else begin
            state <= state_nx;
            unique case (state)
                IDLE: begin
                    if (in_valid) begin
                        r_reg <= in_r;
                        if (in_b == '0) begin
                            out_div0    <= 1'b1;
                            out_sa      <= '0;
                            out_ovf     <= 1'b0;
                            out_rem_bad <= 1'b0;
                        end else begin
                            q_mag <= q_abs_in;
                            b_mag <= b_abs_in;
                            neg   <= in_q[W-1] ^ in_b[W-1];
                            acc   <= '0;
                            cnt   <= '0;
                        end
                    end
                end
                MUL: begin
                    if (q_mag[0])
                        acc <= acc + ({{W{1'b0}}, b_mag} << cnt);
                    q_mag <= q_mag >> 1;
                    if (cnt != CW'(W-1))
                        cnt <= cnt + CW'(1);
                end
                ADD: begin
                    out_sa      <= sum[W-1:0];
                    out_ovf     <= ovf_nx;
                    out_rem_bad <= bad_nx;
                    out_div0    <= 1'b0;
                end
                DONE: ;
                default: ;
            endcase
        end
    end

endmodule

// File: doc/signed_divmod_recon.md
SIGNED_DIVMOD_RECON -- requirements
Module: signed_divmod_recon

Purpose: inverse of the signed divide/modulo path. Takes a quotient, remainder and divisor, rebuilds the dividend as sa = q*b + r with a sequential shift-add multiplier, and flags inconsistent triples.

Interface
REQ-001 The block SHALL have parameter W, default 8, the operand/result width in bits; all values below assume W=8.
REQ-002 The block SHALL run on one clock, and its reset SHALL be asynchronous and active-low.
REQ-003 clk  input  1  rising-edge clock for all state.
REQ-004 rst_n  input  1  asynchronous active-low reset.
REQ-005 in_valid  input  1  request operands present.
REQ-006 in_ready  output  1  block idle, can accept.
REQ-007 in_q  input  W signed  quotient.
REQ-008 in_r  input  W signed  remainder.
REQ-009 in_b  input  W signed  divisor.
REQ-010 out_valid  output  1  result held.
REQ-011 out_ready  input  1  consumer takes result.
REQ-012 out_sa  output  W signed  reconstructed dividend, low W bits.
REQ-013 out_ovf  output  1  q*b+r is outside the signed W-bit range.
REQ-014 out_rem_bad  output  1  remainder inconsistent with truncating division.
REQ-015 out_div0  output  1  divisor was zero.

Function
REQ-016 The FSM SHALL have states IDLE, MUL, ADD and DONE; in_ready SHALL be 1 exactly in IDLE.
REQ-017 Acceptance SHALL occur on an edge with in_valid=1 in IDLE; operands SHALL be registered on that edge.
REQ-018 On acceptance with in_b=0, the next state SHALL be DONE, with out_div0=1, out_sa=0, out_ovf=0 and out_rem_bad=0; out_valid SHALL rise 1 edge after acceptance.
REQ-019 On acceptance with in_b!=0, the block SHALL latch the unsigned magnitudes |q| and |b| (|-128|=128, unsigned W bits) and the product sign q_sign XOR b_sign, clear a 2W-bit accumulator, and enter MUL.
REQ-020 MUL SHALL last exactly W cycles, each cycle doing the following.
- Add |b| shifted by the iteration index to the accumulator when the current LSB of the shifted |q| is 1.
- Shift |q| right by 1.
- Use an iteration counter that runs 0..W-1 and does not wrap.
REQ-021 ADD SHALL take 1 cycle and form the (2W+1)-bit signed sum of the negated-if-sign accumulator and the sign-extended r.
REQ-022 On the ADD-to-DONE transition, the outputs SHALL load as follows.
- out_sa = sum[W-1:0].
- out_ovf = 1 when sum < -2^(W-1) or sum > 2^(W-1)-1.
- out_rem_bad = 1 when r!=0 and either |r| >= |b| or sign(r) != sign(sum); otherwise 0.
- out_div0 = 0.
REQ-023 Non-zero-divisor latency SHALL be W+2 edges from acceptance to out_valid=1 (10 for W=8).
REQ-024 In DONE, out_valid SHALL be 1, and out_sa and all flags SHALL hold stable until the edge with out_ready=1, which returns the FSM to IDLE.
REQ-025 The return to IDLE SHALL clear out_valid, while out_sa and the flags keep their last values.
REQ-026 There SHALL be no overlap between requests: in_valid is ignored outside IDLE, and a new request is accepted no earlier than the edge after the DONE-to-IDLE transition.
REQ-027 Zero operands SHALL need no special case: q=0 or r=0 follows the normal path with no early exit.

Reset
REQ-028 While rst_n=0, the state SHALL be IDLE, so in_ready=1, and out_valid, out_sa, out_ovf, out_rem_bad, out_div0, the accumulator and the counter SHALL all be 0, independent of clk.
REQ-029 Reset asserted in MUL, ADD or DONE SHALL abort the operation immediately with no result emitted.
REQ-030 The first acceptance after rst_n rises SHALL be possible on the first clk edge.

Verification
REQ-031 The bench SHALL cover q=-3, b=5, r=-2 -> after 10 edges: out_sa=-17 (0xEF), ovf=0, rem_bad=0, div0=0.
REQ-032 The bench SHALL cover q=-128, b=-1, r=0 -> out_sa=0x80, ovf=1, rem_bad=0.
REQ-033 The bench SHALL cover q=2, b=5, r=-1 (sum 9, sign mismatch) -> out_sa=9, rem_bad=1; and q=7, b=3, r=5 -> out_sa=26, rem_bad=1.
REQ-034 The bench SHALL cover b=0 with q=4, r=1 -> out_valid 1 edge after acceptance, div0=1, out_sa=0.
REQ-035 The bench SHALL cover out_ready held 0 for 5 cycles in DONE -> out_valid and data stable, in_ready=0, in_valid ignored; out_ready=1 -> IDLE on the next edge.
REQ-036 The bench SHALL cover rst_n pulsed low at the 4th MUL cycle -> out_valid never rises for that request; outputs 0; a new request afterwards completes with correct latency.
